alu_sched: RTL

- Round-robin scheduler sharing one 8-bit combinational alu datapath between NREQ requesters.
- Each requester issues {opcode, a, b} over a valid/ready handshake.
- The scheduler grants one request, registers operands, registers the alu result, and returns it with the requester id over a valid/ready response channel.
- Sits between client blocks and the single alu instance.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 30 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_sched.sv | 132 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, scheduler state encoding and latched-request layout
// for the alu scheduler slice.
package alu_pkg;

  localparam logic [2:0] ALU_PLUS   = 3'd0;
  localparam logic [2:0] ALU_MINUS  = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_NOT    = 3'd4;
  localparam logic [2:0] ALU_OP_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu.sv
// Purpose: 8-bit combinational alu; co is bit 8 of the 9-bit add/sub result.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module alu
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       co
);

  logic [8:0] res9;

  always_comb begin
    res9 = '0;
    case (op)
      ALU_PLUS:  res9 = {1'b0, a} + {1'b0, b};
      ALU_MINUS: res9 = {1'b0, a} - {1'b0, b};
      ALU_AND:   res9 = {1'b0, a & b};
      ALU_OR:    res9 = {1'b0, a | b};
      ALU_NOT:   res9 = {1'b0, ~a};
      default:   res9 = '0;
    endcase
    y  = res9[7:0];
    co = res9[8];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick; search starts one past ptr and wraps, first set bit wins.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides whether the grant is consumed.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Purpose: round-robin share of one alu among NREQ requesters; ALU_FLAGS_EN adds rsp_flags {carry, zero}.
// Latency: request accepted at T -> rsp_valid at T+2; one request in flight, accept only in IDLE.
// Backpressure: rsp_* held while rsp_ready low; req_ready stays 0 until the response is taken.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_opcode,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_data,
  output logic              rsp_err
`ifdef ALU_FLAGS_EN
  ,
  output logic [1:0]        rsp_flags
`endif
);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] ptr_q;
  alu_req_t       op_q;
  alu_req_t       sel;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [7:0]      alu_y;
  logic            alu_co;
  logic            op_ok;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  alu u_alu (
    .op (op_q.op),
    .a  (op_q.a),
    .b  (op_q.b),
    .y  (alu_y),
    .co (alu_co)
  );

  assign op_ok = op_legal(op_q.op);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel = {req_opcode[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // req_ready is gated by rst_n so no grant is ever advertised while in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (rst_n) req_ready = gnt;
        if (gnt_any) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ptr_q doubles as the latched requester id: it only moves on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            op_q  <= sel;
            ptr_q <= gnt_idx;
          end
        end
        EXEC: begin
          rsp_data  <= op_ok ? alu_y : 8'h00;
          rsp_err   <= ~op_ok;
          rsp_id    <= ptr_q;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_flags <= 2'b00;
    end else if (state_q == EXEC) begin
      rsp_flags <= {op_ok & alu_co, op_ok & (alu_y == 8'h00)};
    end
  end
`else
  logic unused_co;
  assign unused_co = alu_co;
`endif

endmodule
